// File: rtl/fixed_point_mul.sv
// Signed saturating fixed-point multiplier (Q(BITSIZE-FRAC-1).FRAC) with one output register.
// Optional macro FXMUL_ROUND_EN selects round-half-up instead of truncation toward -inf.
module fixed_point_mul #(
  parameter int BITSIZE = 16,
  parameter int FRAC    = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BITSIZE-1:0] A,
  input  logic [BITSIZE-1:0] B,
  output logic [BITSIZE-1:0] C,
  output logic               ovf
);

  localparam int PW = 2 * BITSIZE;
  localparam int QW = PW + 1;

  localparam logic signed [QW-1:0] Q_MAX = {{(QW-BITSIZE+1){1'b0}}, {(BITSIZE-1){1'b1}}};
  localparam logic signed [QW-1:0] Q_MIN = {{(QW-BITSIZE+1){1'b1}}, {(BITSIZE-1){1'b0}}};
  localparam logic signed [QW-1:0] RND   = {{(QW-1){1'b0}}, 1'b1} <<< (FRAC - 1);

  logic signed [PW-1:0]      w_a_ext;
  logic signed [PW-1:0]      w_b_ext;
  logic signed [PW-1:0]      w_prod;
  logic signed [QW-1:0]      w_prod_ext;
  logic signed [QW-1:0]      w_sum;
  logic signed [QW-1:0]      w_q;
  logic        [BITSIZE-1:0] w_c;
  logic                      w_ovf;
  logic        [BITSIZE-1:0] r_c;
  logic                      r_ovf;

  // Operands sign-extended to full product width so even (-max)*(-max) is exact.
  assign w_a_ext    = {{BITSIZE{A[BITSIZE-1]}}, A};
  assign w_b_ext    = {{BITSIZE{B[BITSIZE-1]}}, B};
  assign w_prod     = w_a_ext * w_b_ext;
  assign w_prod_ext = {w_prod[PW-1], w_prod};

`ifdef FXMUL_ROUND_EN
  assign w_sum = w_prod_ext + RND;
`else
  assign w_sum = w_prod_ext;
`endif

  assign w_q = w_sum >>> FRAC;

  // Clamp the full-width scaled product into the result range.
  always_comb begin
    w_c   = w_q[BITSIZE-1:0];
    w_ovf = 1'b0;
    if (w_q > Q_MAX) begin
      w_c   = Q_MAX[BITSIZE-1:0];
      w_ovf = 1'b1;
    end else if (w_q < Q_MIN) begin
      w_c   = Q_MIN[BITSIZE-1:0];
      w_ovf = 1'b1;
    end else begin
      w_c   = w_q[BITSIZE-1:0];
      w_ovf = 1'b0;
    end
  end

  // Output register; reset discards any in-flight result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_c   <= {BITSIZE{1'b0}};
      r_ovf <= 1'b0;
    end else begin
      r_c   <= w_c;
      r_ovf <= w_ovf;
    end
  end

  assign C   = r_c;
  assign ovf = r_ovf;

endmodule

// File: tb/tb_fixed_point_mul.sv
// Self-checking bench for fixed_point_mul: directed corners plus a random stream vs. an integer model.
module tb_fixed_point_mul;

  localparam int BITSIZE = 16;
  localparam int FRAC    = 11;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a_s;
  logic [15:0] b_s;
  logic [15:0] c_s;
  logic        ovf_s;

  int n_checks = 0;
  int n_pass   = 0;

  fixed_point_mul #(.BITSIZE(BITSIZE), .FRAC(FRAC)) dut (
    .clk (clk),
    .rst (rst),
    .A   (a_s),
    .B   (b_s),
    .C   (c_s),
    .ovf (ovf_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference: exact integer product, optional +half LSB, floor divide, clamp.
  function automatic logic [16:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    longint p;
    longint q;
    logic [15:0] lo;
    p = longint'($signed(a)) * longint'($signed(b));
`ifdef FXMUL_ROUND_EN
    p = p + 64'sd1024;
`endif
    q = p / 64'sd2048;
    if ((q * 64'sd2048) > p) q = q - 64'sd1;
    if (q > 64'sd32767) return {1'b1, 16'h7FFF};
    if (q < -64'sd32768) return {1'b1, 16'h8000};
    lo = q[15:0];
    return {1'b0, lo};
  endfunction

  task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c_exp, input logic o_exp);
    @(negedge clk);
    a_s = a;
    b_s = b;
    @(negedge clk);
    check({tag, "_C"}, {16'h0, c_s}, {16'h0, c_exp});
    check({tag, "_ovf"}, {31'h0, ovf_s}, {31'h0, o_exp});
  endtask

  logic [16:0] exp_q[$];
  logic [16:0] e;
  logic [15:0] ra;
  logic [15:0] rb;

  initial begin
    rst = 1'b1;
    a_s = 16'h1234;
    b_s = 16'h5678;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_C", {16'h0, c_s}, 32'h0);
    check("reset_ovf", {31'h0, ovf_s}, 32'h0);
    rst = 1'b0;

    directed("half_sq",   16'h0400, 16'h0400, 16'h0200, 1'b0);
    directed("exact",     16'h4000, 16'h0400, 16'h2000, 1'b0);
    directed("neg_small", 16'hFFFF, 16'h4000, 16'hFFF8, 1'b0);
    directed("times_one", 16'h8001, 16'h0800, 16'h8001, 1'b0);
    directed("sat_pos",   16'h7FFF, 16'h1000, 16'h7FFF, 1'b1);
    directed("sat_neg1",  16'h8400, 16'h4000, 16'h8000, 1'b1);
    directed("sat_neg2",  16'h4000, 16'hC000, 16'h8000, 1'b1);
    directed("sat_negneg",16'hC000, 16'hC000, 16'h7FFF, 1'b1);
    directed("min_min",   16'h8000, 16'h8000, 16'h7FFF, 1'b1);
    directed("zero",      16'h8000, 16'h0000, 16'h0000, 1'b0);
`ifdef FXMUL_ROUND_EN
    directed("rnd_up",    16'h0001, 16'h0400, 16'h0001, 1'b0);
    directed("rnd_neg",   16'hFFFF, 16'h0400, 16'h0000, 1'b0);
`else
    directed("trunc_pos", 16'h0001, 16'h0400, 16'h0000, 1'b0);
    directed("trunc_neg", 16'hFFFF, 16'h0400, 16'hFFFF, 1'b0);
`endif

    // Back-to-back stream with a one-cycle reset in the middle.
    for (int i = 0; i <= 100; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = exp_q.pop_front();
        check($sformatf("stream%0d_C", i), {16'h0, c_s}, {16'h0, e[15:0]});
        check($sformatf("stream%0d_ovf", i), {31'h0, ovf_s}, {31'h0, e[16]});
      end
      if (i < 100) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        if (i % 4 == 1) rb = 16'($urandom_range(0, 16'h0FFF));
        a_s = ra;
        b_s = rb;
        if (i == 50) begin
          rst = 1'b1;
          exp_q.push_back(17'h0);
        end else begin
          rst = 1'b0;
          exp_q.push_back(ref_mul(ra, rb));
        end
      end else begin
        rst = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fixed_point_mul.md
# fixed_point_mul

Signed fixed-point multiplier with saturation and a single registered output stage. It multiplies two BITSIZE-bit two's-complement operands with FRAC fractional bits (default Q4.11) and returns a product in the same format. The result is clamped to the representable range. It is a datapath primitive for the arithmetic pipeline, where it sits alongside the fixed-point adder in neuron and MAC datapaths.

## Interface
- BITSIZE, default 16: total operand and result width, sign bit included.
- FRAC, default 11: number of fractional bits, with 1 ≤ FRAC ≤ BITSIZE-2.
- One clock; reset is synchronous and active-high.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- A  input  BITSIZE  multiplicand, two's complement, FRAC fractional bits.
- B  input  BITSIZE  multiplier, same format as A.
- C  output  BITSIZE  registered product, same format as A.
- ovf  output  1  registered flag; high when the C value registered in the same cycle was saturated.

## Operation
- Format: value = signed integer(X) / 2^FRAC. Default range is -16.0 (0x8000) to +15.99951 (0x7FFF), LSB = 1/2048.
- Full product:
  - P = signed(A) × signed(B), computed at 2·BITSIZE bits with no intermediate loss.
  - The case A = B = most-negative is handled: P = 2^(2·BITSIZE-2).
- Scaling: Q = P >>> FRAC. This is an arithmetic shift, so truncation is toward −∞ (default build).
- Saturation:
  - If Q > 2^(BITSIZE-1)−1, the result is 2^(BITSIZE-1)−1 (0x7FFF) and ovf=1.
  - If Q < −2^(BITSIZE-1), the result is −2^(BITSIZE-1) (0x8000) and ovf=1.
  - Otherwise the result is Q[BITSIZE-1:0] and ovf=0.
- Detection compares the full-width Q against the bounds. Checking only sign bits is not sufficient.
- Rounding is applied before the saturation check when enabled (see Configuration).
- There is no handshake. A and B are sampled every cycle, and a new result is produced every cycle.

## Timing
- Latency: 1 cycle. The C and ovf values present after rising edge k are computed from the A and B sampled at edge k.
- Throughput: 1 result per cycle.
- The multiply, shift and saturate path is fully combinational between input sampling and the output register. There are no internal pipeline registers.
- Reset:
  - On a rising edge with rst=1, C ← 0 and ovf ← 0. Inputs are ignored that cycle.
  - The first valid result appears at the first edge with rst=0.
- Reset mid-stream: the in-flight result is discarded. Outputs read 0 on the next edge, then resume normal operation.
- Outputs are glitch-free, because they are driven only by flops.

## Configuration
- Macro FXMUL_ROUND_EN:
  - Defined: round-half-up. Q = (P + 2^(FRAC-1)) >>> FRAC. The addition is done at 2·BITSIZE+1 bits so it cannot wrap. Saturation is applied afterwards.
  - Undefined (default): pure truncation toward −∞, as described in Operation.
- Latency, ports and saturation behaviour are identical in both builds.

## Test plan
- Reset, then basic products:
  - rst=1 for 2 edges → C=0x0000, ovf=0.
  - Release reset, A=0x0400, B=0x0400 (0.5×0.5) → next edge C=0x0200 (0.25), ovf=0.
- Exact and negative products:
  - A=0x4000, B=0x0400 (8×0.5) → C=0x2000, ovf=0.
  - A=0xFFFF, B=0x4000 → C=0xFFF8, ovf=0.
  - A=0x8001, B=0x0800 (×1.0) → C=0x8001.
- Saturation, one case per sign:
  - A=0x7FFF, B=0x1000 → C=0x7FFF, ovf=1.
  - A=0x8400, B=0x4000 (−15.5×8) → C=0x8000, ovf=1.
  - A=0x4000, B=0xC000 → C=0x8000, ovf=1.
  - A=0xC000, B=0xC000 (−8×−8) → C=0x7FFF, ovf=1.
- Rounding:
  - A=0x0001, B=0x0400 → C=0x0000 with the macro undefined.
  - Same inputs → C=0x0001 with FXMUL_ROUND_EN defined.
  - A=0xFFFF, B=0x0400 → C=0xFFFF when undefined, 0x0000 when defined.
- Throughput and reset:
  - Change A/B every cycle for 100 random pairs → each C matches the reference model exactly one cycle later.
  - Assert rst for one cycle mid-stream → C=0 and ovf=0 on that edge, with correct results on the following edge.
